// File: rtl/recall_pkg.sv
// Shared types and constants for the recall sequence-memory game engine.
package recall_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_SHOW  = 3'd2,
        S_GAP   = 3'd3,
        S_INPUT = 3'd4
    } recall_state_t;

    // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [2:0] recall_len(input logic [1:0] difficulty);
        return {1'b0, difficulty} + 3'd3;
    endfunction

endpackage

// File: rtl/recall_lfsr.sv
// 16-bit Galois LFSR with enable; asynchronous reset returns it to the seed.
module recall_lfsr
    import recall_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] value
);

    // Shift right, folding the taps in whenever a one falls out of bit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (en) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/recall_seq_engine.sv
// Sequence-memory game: generate, show on LEDs, then check switch presses.
// Optional input timeout in INPUT is enabled by defining RECALL_TIMEOUT_EN.
module recall_seq_engine
    import recall_pkg::*;
#(
    parameter int NUM_SW        = 10,
    parameter int MAX_LEN       = 8,
    parameter int SHOW_TICKS    = 25_000_000,
    parameter int SCORE_W       = 8,
    parameter int TIMEOUT_TICKS = 250_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         difficulty,
    input  logic [NUM_SW-1:0]  sw,
    output logic [NUM_SW-1:0]  light,
    output logic [SCORE_W-1:0] score,
    output logic               success,
    output logic               fail,
    output logic               busy
);

    localparam int IDX_W  = $clog2(NUM_SW);
    localparam int POS_W  = $clog2(MAX_LEN);
    localparam int TICK_W = $clog2(SHOW_TICKS);
    localparam logic [TICK_W-1:0] SHOW_LAST = TICK_W'(SHOW_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(SHOW_TICKS / 2 - 1);

    function automatic logic [NUM_SW-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_SW-1){1'b0}}, 1'b1} << idx;
    endfunction

    recall_state_t     state_r, state_nx_s;
    logic [POS_W-1:0]  pos_r, pos_nx_s, len_r;
    logic [TICK_W-1:0] tick_r, tick_nx_s;
    logic [IDX_W-1:0]  seq_r [MAX_LEN];
    logic [IDX_W-1:0]  last_r, gen_raw_s, gen_val_s;
    logic [NUM_SW-1:0] prev_sw_r, rise_s, want_s;
    logic [15:0]       lfsr_s;
    logic              last_pos_s, hit_s, pass_s, miss_s, to_hit_s;

    recall_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .value (lfsr_s)
    );

    assign gen_raw_s  = IDX_W'(lfsr_s % 16'(NUM_SW));
    assign rise_s     = sw & ~prev_sw_r;
    assign want_s     = onehot(seq_r[pos_r]);
    // want_s is one-hot, so equality also rules out a second rising bit
    assign hit_s      = (rise_s == want_s);
    assign last_pos_s = (pos_r == len_r - POS_W'(1));

    // Avoid an immediate repeat of the previous sequence entry
    always_comb begin
        gen_val_s = gen_raw_s;
        if (pos_r != {POS_W{1'b0}} && gen_raw_s == last_r) begin
            gen_val_s = (gen_raw_s == IDX_W'(NUM_SW - 1)) ? {IDX_W{1'b0}} : gen_raw_s + IDX_W'(1);
        end else begin
            gen_val_s = gen_raw_s;
        end
    end

`ifdef RECALL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS);
    logic [TO_W-1:0] to_cnt_r;

    assign to_hit_s = (to_cnt_r == TO_W'(TIMEOUT_TICKS - 1));

    // Idle-input counter, restarted on entry and on every accepted press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r != S_INPUT || (rise_s != {NUM_SW{1'b0}} && hit_s)) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end
`else
    assign to_hit_s = 1'b0;
`endif

    // Next-state, position and tick control
    always_comb begin
        state_nx_s = state_r;
        pos_nx_s   = pos_r;
        tick_nx_s  = tick_r;
        pass_s     = 1'b0;
        miss_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_GEN;
                    pos_nx_s   = {POS_W{1'b0}};
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_GEN: begin
                tick_nx_s = {TICK_W{1'b0}};
                if (last_pos_s) begin
                    state_nx_s = S_SHOW;
                    pos_nx_s   = {POS_W{1'b0}};
                end else begin
                    pos_nx_s = pos_r + POS_W'(1);
                end
            end
            S_SHOW: begin
                if (tick_r == SHOW_LAST) begin
                    state_nx_s = S_GAP;
                    tick_nx_s  = {TICK_W{1'b0}};
                end else begin
                    tick_nx_s = tick_r + TICK_W'(1);
                end
            end
            S_GAP: begin
                if (tick_r != GAP_LAST) begin
                    tick_nx_s = tick_r + TICK_W'(1);
                end else if (last_pos_s) begin
                    state_nx_s = S_INPUT;
                    pos_nx_s   = {POS_W{1'b0}};
                    tick_nx_s  = {TICK_W{1'b0}};
                end else begin
                    state_nx_s = S_SHOW;
                    pos_nx_s   = pos_r + POS_W'(1);
                    tick_nx_s  = {TICK_W{1'b0}};
                end
            end
            S_INPUT: begin
                if (rise_s != {NUM_SW{1'b0}}) begin
                    if (!hit_s) begin
                        miss_s     = 1'b1;
                        state_nx_s = S_IDLE;
                    end else if (last_pos_s) begin
                        pass_s     = 1'b1;
                        state_nx_s = S_IDLE;
                    end else begin
                        pos_nx_s = pos_r + POS_W'(1);
                    end
                end else if (to_hit_s) begin
                    miss_s     = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_INPUT;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            pos_r     <= {POS_W{1'b0}};
            tick_r    <= {TICK_W{1'b0}};
            len_r     <= {POS_W{1'b0}};
            prev_sw_r <= {NUM_SW{1'b0}};
            light     <= {NUM_SW{1'b0}};
            score     <= {SCORE_W{1'b0}};
            success   <= 1'b0;
            fail      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pos_r     <= pos_nx_s;
            tick_r    <= tick_nx_s;
            prev_sw_r <= sw;
            if (state_r == S_IDLE && start) begin
                len_r <= POS_W'(recall_len(difficulty));
            end
            light   <= (state_nx_s == S_SHOW) ? onehot(seq_r[pos_nx_s]) : {NUM_SW{1'b0}};
            success <= pass_s;
            fail    <= miss_s;
            busy    <= (state_nx_s != S_IDLE);
            if (pass_s && !(&score)) begin
                score <= score + SCORE_W'(1);
            end
        end
    end

    // Sequence storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (state_r == S_GEN) begin
            seq_r[pos_r] <= gen_val_s;
            last_r       <= gen_val_s;
        end
    end

endmodule

// File: tb/tb_recall_seq_engine.sv
// Self-checking bench for recall_seq_engine: table of rounds against a sequence model.
module tb_recall_seq_engine;

    localparam int NUM_SW = 10;
    localparam int SHOW   = 4;
    localparam int GAP    = 2;

    localparam int M_OK     = 0;
    localparam int M_WRONG  = 1;
    localparam int M_DOUBLE = 2;
    localparam int M_HOLD   = 3;
    localparam int M_WAIT   = 4;

    typedef struct {
        logic [1:0] diff;
        int         mode;
        int         at;
        bit         exp_pass;
    } round_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        difficulty = 2'd0;
    logic [NUM_SW-1:0] sw = '0;
    logic [NUM_SW-1:0] light;
    logic [1:0]        score;
    logic              success, fail, busy;

    int          checks = 0;
    int          errors = 0;
    int          exp_score = 0;
    int          exp_seq [8];
    logic [15:0] m_lfsr;
    round_t      tbl [8];

    recall_seq_engine #(
        .NUM_SW        (NUM_SW),
        .MAX_LEN       (8),
        .SHOW_TICKS    (SHOW),
        .SCORE_W       (2),
        .TIMEOUT_TICKS (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .difficulty (difficulty),
        .sw         (sw),
        .light      (light),
        .score      (score),
        .success    (success),
        .fail       (fail),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Galois step for x^16+x^14+x^13+x^11+1: shift right, xor taps when a one leaves bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Reference LFSR, free-running like the one in the engine
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected sequence from the LFSR values seen during the L generate cycles
    task automatic predict(input int len);
        logic [15:0] v;
        int val;
        v = m_lfsr;
        for (int i = 0; i < len; i++) begin
            v = lfsr_step(v);
            val = int'(v) % NUM_SW;
            if (i > 0 && val == exp_seq[i-1]) val = (val + 1) % NUM_SW;
            exp_seq[i] = val;
        end
    endtask

    task automatic run_round(input round_t r);
        int len, bad, off, k;
        logic [NUM_SW-1:0] expl, want;
        bit decide;
        len = int'(r.diff) + 3;
        start = 1'b1;
        difficulty = r.diff;
        predict(len);
        if (r.mode == M_HOLD) sw = NUM_SW'(1) << exp_seq[0];
        @(negedge clk);
        start = 1'b0;
        difficulty = ~r.diff;
        check("busy_rise", 32'(busy), 32'd1);
        bad = 0;
        for (int c = 1; c <= len * 7; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= len) begin
                expl = '0;
            end else begin
                off = c - len - 1;
                expl = ((off % (SHOW + GAP)) < SHOW) ? (NUM_SW'(1) << exp_seq[off / (SHOW + GAP)]) : '0;
            end
            if (light !== expl) bad++;
        end
        check("light_trace", 32'(bad), 32'd0);
        @(negedge clk);
        check("input_busy", 32'(busy), 32'd1);
        if (r.mode == M_HOLD) begin
            repeat (3) @(negedge clk);
            check("hold_no_event", 32'({success, fail, busy}), 32'b001);
            sw = '0;
            @(negedge clk);
        end
        if (r.mode == M_WAIT) begin
`ifdef RECALL_TIMEOUT_EN
            // fail shows in the cycle after 20 idle INPUT cycles
            k = 1;
            while (!fail && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("timeout_cycle", 32'(k), 32'd21);
            check("timeout_busy", 32'(busy), 32'd0);
            check("timeout_score", 32'(score), 32'(exp_score));
            @(negedge clk);
            check("timeout_pulse_len", 32'(fail), 32'd0);
            return;
`else
            k = 0;
            repeat (40) begin
                @(negedge clk);
                if (fail || success || !busy) k++;
            end
            check("no_timeout", 32'(k), 32'd0);
`endif
        end
        for (int i = 0; i < len; i++) begin
            want = NUM_SW'(1) << exp_seq[i];
            decide = (i == len - 1) || ((r.mode == M_WRONG || r.mode == M_DOUBLE) && i == r.at);
            if (r.mode == M_WRONG && i == r.at)
                sw = NUM_SW'(1) << ((exp_seq[i] + 3) % NUM_SW);
            else if (r.mode == M_DOUBLE && i == r.at)
                sw = want | (NUM_SW'(1) << ((exp_seq[i] + 1) % NUM_SW));
            else
                sw = want;
            @(negedge clk);
            if (decide) begin
                if (r.exp_pass) exp_score = (exp_score == 3) ? 3 : exp_score + 1;
                check("success", 32'(success), 32'(r.exp_pass));
                check("fail", 32'(fail), 32'(!r.exp_pass));
                check("busy_fall", 32'(busy), 32'd0);
                check("score", 32'(score), 32'(exp_score));
                sw = '0;
                @(negedge clk);
                check("pulse_len", 32'({success, fail}), 32'd0);
                break;
            end
            check("mid_press", 32'({success, fail, busy}), 32'b001);
            sw = '0;
            @(negedge clk);
        end
    endtask

    initial begin
        int bad;
        round_t ok;
        tbl[0] = '{2'd0, M_OK,     0, 1'b1};
        tbl[1] = '{2'd0, M_WRONG,  1, 1'b0};
        tbl[2] = '{2'd1, M_DOUBLE, 1, 1'b0};
        tbl[3] = '{2'd2, M_HOLD,   0, 1'b1};
        tbl[4] = '{2'd3, M_OK,     0, 1'b1};
        tbl[5] = '{2'd1, M_OK,     0, 1'b1};
        tbl[6] = '{2'd0, M_OK,     0, 1'b1};
`ifdef RECALL_TIMEOUT_EN
        tbl[7] = '{2'd0, M_WAIT,   0, 1'b0};
`else
        tbl[7] = '{2'd0, M_WAIT,   0, 1'b1};
`endif

        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({light, score, success, fail, busy} !== '0) bad++;
        end
        check("idle_outputs", 32'(bad), 32'd0);

        for (int i = 0; i < 8; i++) run_round(tbl[i]);

        // Reset in the middle of SHOW aborts with no pulse
        start = 1'b1;
        difficulty = 2'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("show_lit", 32'(light != '0), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_light", 32'(light), 32'd0);
        check("reset_flags", 32'({success, fail, busy}), 32'd0);
        check("reset_score", 32'(score), 32'd0);
        exp_score = 0;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({light, success, fail, busy} !== '0) bad++;
        end
        check("post_reset_quiet", 32'(bad), 32'd0);

        ok = '{2'd2, M_OK, 0, 1'b1};
        run_round(ok);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/recall_seq_engine.md
# recall_seq_engine

Parametrised sequence-memory game engine for the lab board. On `start` it generates a pseudo-random sequence of switch indices whose length is set by `difficulty`, plays it back on the LEDs, then checks the player's switch presses against it. It reports a pass/fail pulse and keeps a saturating score for the seven-segment display logic. It sits between the debounced switch/LED board I/O and the display decoder.

## Interface
- `NUM_SW`, 10, number of switches/LEDs; 2..16
- `MAX_LEN`, 8, sequence storage depth; must be ≥ 6
- `SHOW_TICKS`, 25_000_000, cycles each LED stays lit; ≥ 2
- `SCORE_W`, 8, score counter width
- `TIMEOUT_TICKS`, 250_000_000, input timeout in cycles (used only with the macro)

- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: start-round request; sampled only in IDLE
- `difficulty` in 2: sequence length L = difficulty + 3 (3..6); sampled on accepted `start`
- `sw` in NUM_SW: debounced, synchronised switch levels
- `light` out NUM_SW: one-hot during SHOW, else 0
- `score` out SCORE_W: rounds passed, saturating at all-ones
- `success` out 1: one-cycle pulse on a passed round
- `fail` out 1: one-cycle pulse on a failed round
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, GEN, SHOW, GAP, INPUT.
- IDLE:
  - `start`=1 → GEN.
  - Latch L.
  - Clear the position counter `pos`.
- GEN, L cycles:
  - Each cycle writes `seq[pos] = lfsr % NUM_SW`.
  - If that value equals `seq[pos-1]`, write (value+1) % NUM_SW instead.
  - After the last write → SHOW with `pos`=0.
- SHOW, SHOW_TICKS cycles:
  - `light` = one-hot of `seq[pos]`.
  - Then → GAP.
- GAP, SHOW_TICKS/2 cycles:
  - `light`=0.
  - Then `pos`++; if `pos`==L → INPUT with `pos`=0, else → SHOW.
- INPUT:
  - On entry, the previous-switch register loads `sw`, so levels already held never count as presses.
  - Press = any 0→1 bit transition.
  - Exactly one rising bit equal to `seq[pos]` → `pos`++.
  - If that makes `pos`==L → `success` pulse, `score`+1 (saturating) → IDLE.
  - Wrong bit, or ≥2 bits rising in the same cycle → `fail` pulse → IDLE; `score` unchanged.
  - Falling edges are ignored.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Free-runs every cycle in all states, so the time of `start` randomises the sequence.
- `start` outside IDLE is ignored.
- `difficulty` changes mid-round have no effect.

## Timing
- Reset values:
  - State IDLE; `light`=0, `score`=0, `success`=0, `fail`=0, `busy`=0.
  - `pos`=0, LFSR=16'hACE1, `seq` contents don't-care.
- `start` high at edge n → `busy`=1 from n+1.
- The first LED lights at n+1+L.
- All outputs are registered.
- `success`/`fail` assert the cycle after the sampling edge that saw the deciding press, and last exactly one cycle.
- `busy` falls in the same cycle that `success`/`fail` rises.
- A new `start` is accepted in the cycle after `busy` falls.
- Reset asserted mid-round aborts immediately to the reset values; no pulse is emitted.

## Configuration
- `RECALL_TIMEOUT_EN` defined:
  - In INPUT, a counter clears on entry and on each accepted correct press.
  - Reaching TIMEOUT_TICKS-1 produces a `fail` pulse → IDLE.
- Not defined:
  - No counter exists; INPUT waits indefinitely.
  - The `TIMEOUT_TICKS` parameter is unused.

## Structure
- `recall_pkg` holds:
  - The state enum `recall_state_t`.
  - `LFSR_SEED` and `LFSR_TAPS` constants.
  - The function mapping `difficulty` to L.
- Sub-module `recall_lfsr`: 16-bit Galois LFSR with enable and async reset to seed.
- Everything else lives in the top module.

## Test plan
- Reset, then idle for 100 cycles → all outputs 0, `busy`=0.
- NUM_SW=10, SHOW_TICKS=4, difficulty=2'b00:
  - `start` → exactly 3 one-hot `light` pulses, each 4 cycles with 2-cycle gaps.
  - Bench replays the captured indices as 0→1 presses → `success` one cycle, `score`=1.
- Same setup with the second press wrong → `fail` one cycle, `score` stays 1, `busy`=0 next.
- Press two switches rising in the same cycle during INPUT → `fail`.
- A switch held high entering INPUT is not counted; raising a held bit never fires.
- SCORE_W=2, pass 5 rounds → `score` sticks at 3.
- With `RECALL_TIMEOUT_EN`, TIMEOUT_TICKS=20: no input for 20 cycles → `fail`.
- Assert `reset` during SHOW → `light`=0 immediately, no pulse.
